pfb_mac_result_drain: RTL
=========================

// Module: pfb_mac_result_drain
// PURPOSE
// Consumer end of the PFB multiply-accumulate cascade. Tracks sample validity through the
// ce-gated pipeline of the MAC chain and captures each 48-bit chain sum once.
// Rounds, shifts and saturates the sum to OUT_W bits, buffers it in a FIFO and
// presents it as AXI-Stream, with tlast marking the last channel of each frame.
// PARAMETERS
// PIPE_LAT    11  ce-cycles from a/b presented with in_valid to the chain sum on p_in
// SHIFT       15  right shift applied after rounding (2..47)
// OUT_W       16  output sample width (2..32)
// NUM_CHAN    64  channels per frame; tlast period (power of 2 not required, >=2)
// FIFO_DEPTH  16  output FIFO entries (power of 2, >=4)
// AFULL_LVL    4  almost_full asserts when free entries <= AFULL_LVL
// PORTS
// clk         in   1      clock
// rst         in   1      asynchronous reset, active-high
// ce          in   1      same clock enable that drives the MAC chain registers
// in_valid    in   1      sample on chain inputs is real; qualified by ce
// p_in        in   48     P output of the last MAC in the chain (signed)
// clr_flags   in   1      synchronous clear of sat_flag and ovf_flag
// m_tdata     out  OUT_W  rounded/saturated sample (signed)
// m_tvalid    out  1      AXI-Stream valid
// m_tready    in   1      AXI-Stream ready
// m_tlast     out  1      high on channel NUM_CHAN-1 of each frame
// almost_full out  1      upstream must drop ce while high
// sat_flag    out  1      sticky: a sample saturated
// ovf_flag    out  1      sticky: a sample was dropped, FIFO full
// BEHAVIOUR
// Reset: all outputs 0. Tracker, channel counter, FIFO pointers and flags are cleared. FIFO is empty.
// Tracker:
// - PIPE_LAT-bit shift register; on ce=1 shifts in in_valid. Holds when ce=0.
// - Tail bit tv=1 means p_in holds a valid sum.
// Capture:
// - Occurs when ce & tv, so a result held during ce=0 is captured exactly once.
// Arithmetic, registered one cycle after capture:
// - r = sext49(p_in) + 2^(SHIFT-1); q = r >>> SHIFT (arithmetic).
// - If q > 2^(OUT_W-1)-1, output the max and set sat_flag.
// - If q < -2^(OUT_W-1), output the min and set sat_flag.
// - Otherwise output q[OUT_W-1:0].
// Channel counter:
// - Increments on every capture, including captures that are dropped, so frame alignment survives overflow.
// - Wraps from NUM_CHAN-1 to 0. Each word's tlast = (counter == NUM_CHAN-1) at capture time.
// FIFO write: one cycle after capture.
// - If full and no read this cycle, drop the word and set ovf_flag.
// - If full and a read occurs in the same cycle, the write succeeds.
// FIFO output is first-word-fall-through.
// - m_tvalid = !empty; pop on m_tvalid & m_tready.
// - m_tdata and m_tlast stay stable while m_tvalid & !m_tready.
// Latency:
// - Capture to m_tvalid is 2 clk when the FIFO is empty.
// - p_in to m_tdata is combinationally isolated (registered).
// almost_full: registered from the FIFO count. Upstream needs AFULL_LVL >= 2 plus the in-flight tracker count for a lossless drop of ce.
// clr_flags:
// - Clears both flags.
// - A set event in the same cycle wins.
// Reset mid-frame: in-flight and buffered samples are discarded and the counter restarts at 0.
// TESTING
// 1. Reset, then in_valid=1 with ce=1 for 1 cycle; p_in=48'sd98304 at tv -> m_tdata=3, m_tvalid 2 clk after capture.
// 2. Rounding: p_in=16384 -> 1; 16383 -> 0; -16384 -> 0; -16385 -> -1 (SHIFT=15).
// 3. Saturation: p_in=2^40 -> 32767 and sat_flag=1; p_in=-2^40 -> -32768. clr_flags -> sat_flag=0.
// 4. Toggle ce 1/0 with tv held high across ce=0 cycles -> exactly one word per ce-qualified capture.
// 5. 130 captures with m_tready=1 -> m_tlast on words 63 and 127; 130th word has tlast=0.
// 6. m_tready=0 and 20 captures with FIFO_DEPTH=16 -> almost_full at 12 entries; 4 words dropped, ovf_flag=1.
//    Drain -> 16 words; next frame's tlast still lands on channel 63.

Source files
------------

// File: rtl/pfb_mac_result_drain.sv
// pfb_mac_result_drain
// Consumer end of the PFB multiply-accumulate cascade. A validity tracker
// follows each sample through the ce-gated MAC pipeline so that every 48-bit
// chain sum is captured exactly once. Each captured sum is rounded, shifted
// and saturated to OUT_W bits. The result goes into a first-word-fall-through
// FIFO and leaves as AXI-Stream. tlast marks channel NUM_CHAN-1 of every frame.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   ce           clock enable shared with the MAC chain registers
//   in_valid     chain input sample is real (qualified by ce)
//   p_in         signed 48-bit P output of the last MAC
//   clr_flags    synchronous clear of sat_flag / ovf_flag
//   m_tdata      signed OUT_W-bit output sample
//   m_tvalid     AXI-Stream valid (FIFO not empty)
//   m_tready     AXI-Stream ready
//   m_tlast      last channel of the frame
//   almost_full  registered; upstream drops ce while high
//   sat_flag     sticky: a sample saturated
//   ovf_flag     sticky: a sample was dropped because the FIFO was full
module pfb_mac_result_drain #(
  parameter int PIPE_LAT   = 11,
  parameter int SHIFT      = 15,
  parameter int OUT_W      = 16,
  parameter int NUM_CHAN   = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_LVL  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [47:0]      p_in,
  input  logic             clr_flags,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             almost_full,
  output logic             sat_flag,
  output logic             ovf_flag
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CHW = $clog2(NUM_CHAN);

  localparam logic signed [48:0] ROUND = 49'sd1 <<< (SHIFT - 1);
  localparam logic signed [48:0] MAX_Q = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
  localparam logic signed [48:0] MIN_Q = -(49'sd1 <<< (OUT_W - 1));

  localparam logic [OUT_W-1:0] MAX_W = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_W = {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  AF_THRESH = CW'(FIFO_DEPTH - AFULL_LVL);
  localparam logic [CHW-1:0] LAST_CHAN = CHW'(NUM_CHAN - 1);

  // Validity tracker: mirrors the ce-gated MAC pipeline depth
  logic [PIPE_LAT-1:0] trk;
  logic                tv;
  logic                capture;

  assign tv      = trk[PIPE_LAT-1];
  assign capture = ce & tv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trk <= '0;
    else if (ce)
      trk <= (trk << 1) | PIPE_LAT'(in_valid);
  end

  // Round half up, arithmetic shift, then clamp into the signed OUT_W range
  logic signed [48:0] r_sum;
  logic signed [48:0] q_val;
  logic [OUT_W-1:0]   q_word;
  logic               sat_hit;

  always_comb begin
    r_sum   = {p_in[47], p_in} + ROUND;
    q_val   = r_sum >>> SHIFT;
    q_word  = q_val[OUT_W-1:0];
    sat_hit = 1'b0;
    if (q_val > MAX_Q) begin
      q_word  = MAX_W;
      sat_hit = 1'b1;
    end else if (q_val < MIN_Q) begin
      q_word  = MIN_W;
      sat_hit = 1'b1;
    end
  end

  // Result stage and channel counter. The counter advances on every capture,
  // even when the word is later dropped, so frame alignment survives overflow.
  logic             s1_valid;
  logic [OUT_W-1:0] s1_data;
  logic             s1_last;
  logic [CHW-1:0]   chan;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      chan     <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_data <= q_word;
        s1_last <= (chan == LAST_CHAN);
        chan    <= (chan == LAST_CHAN) ? '0 : chan + CHW'(1);
      end
    end
  end

  // FIFO control: a write into a full FIFO still succeeds if a read happens
  // in the same cycle; otherwise the word is dropped.
  logic [OUT_W:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  always_comb begin
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    pop       = !empty & m_tready;
    push      = s1_valid & (!full | pop);
    drop      = s1_valid & full & !pop;
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {s1_last, s1_data};
  end

  // almost_full is registered from the next count so it tracks occupancy
  // without an extra cycle of lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_THRESH);
    end
  end

  // Sticky flags: a set event in the same cycle beats clr_flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (capture & sat_hit)
        sat_flag <= 1'b1;
      else if (clr_flags)
        sat_flag <= 1'b0;
      if (drop)
        ovf_flag <= 1'b1;
      else if (clr_flags)
        ovf_flag <= 1'b0;
    end
  end

  // First-word-fall-through output. Memory contents are not reset, so the
  // head word is masked to zero while the FIFO is empty.
  always_comb begin
    m_tvalid = !empty;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    if (!empty) begin
      m_tdata = mem[rd_ptr][OUT_W-1:0];
      m_tlast = mem[rd_ptr][OUT_W];
    end
  end

endmodule
